// File: rtl/counter_universal_wrap_if.sv
`default_nettype none
// ============================================================================
// Module      : counter_universal_wrap_if
// Description : Control/data bundle for the universal wrap counter.
// Revision    : 1.0 - initial release
// ============================================================================
interface counter_universal_wrap_if #(
    parameter int WIDTH = 8
);
    logic             en;
    logic             l;
    logic             lw;
    logic             inc;
    logic             dec;
    logic             shl;
    logic             shr;
    logic             rot;
    logic             sin;
    logic [WIDTH-1:0] d;
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] wl_q;
    logic             wrap;
    logic             sout;
    logic             zero;
    logic             at_lim;

    modport master (
        output en, l, lw, inc, dec, shl, shr, rot, sin, d,
        input  q, wl_q, wrap, sout, zero, at_lim
    );

    modport slave (
        input  en, l, lw, inc, dec, shl, shr, rot, sin, d,
        output q, wl_q, wrap, sout, zero, at_lim
    );
endinterface
`default_nettype wire

// File: rtl/counter_universal_wrap.sv
`default_nettype none
// ============================================================================
// Module      : counter_universal_wrap
// Description : N-bit load/inc/dec/shift counter with programmable wrap limit.
// Revision    : 1.0 - initial release
// ============================================================================
module counter_universal_wrap #(
    parameter int               WIDTH   = 8,
    parameter logic [WIDTH-1:0] LIM_RST = {WIDTH{1'b1}}
) (
    input  wire logic              C,
    input  wire logic              R,
    counter_universal_wrap_if.slave bus
);

    localparam logic [WIDTH-1:0] c_zero = '0;
    localparam logic [WIDTH-1:0] c_one  = WIDTH'(1);

    logic [WIDTH-1:0] r_q;
    logic [WIDTH-1:0] r_wl;
    logic             r_wrap;
    logic             r_sout;

    always_ff @(posedge C) begin
        if (R) begin
            r_q    <= c_zero;
            r_wl   <= LIM_RST;
            r_wrap <= 1'b0;
            r_sout <= 1'b0;
        end else begin
            // The limit update never affects this cycle's Q comparisons,
            // which still see the old r_wl.
            if (bus.lw) begin
                r_wl <= bus.d;
            end
            r_wrap <= 1'b0;
            if (bus.en) begin
                if (bus.l) begin
                    r_q <= bus.d;
                end else if (bus.inc) begin
                    if (r_q >= r_wl) begin
                        r_q    <= c_zero;
                        r_wrap <= 1'b1;
                    end else begin
                        r_q <= r_q + c_one;
                    end
                end else if (bus.dec) begin
                    if (r_q == c_zero) begin
                        r_q    <= r_wl;
                        r_wrap <= 1'b1;
                    end else begin
                        r_q <= r_q - c_one;
                    end
                end else if (bus.shl) begin
                    r_q    <= {r_q[WIDTH-2:0], (bus.rot ? r_q[WIDTH-1] : bus.sin)};
                    r_sout <= r_q[WIDTH-1];
                end else if (bus.shr) begin
                    r_q    <= {(bus.rot ? r_q[0] : bus.sin), r_q[WIDTH-1:1]};
                    r_sout <= r_q[0];
                end
            end
        end
    end

    assign bus.q      = r_q;
    assign bus.wl_q   = r_wl;
    assign bus.wrap   = r_wrap;
    assign bus.sout   = r_sout;
    assign bus.zero   = (r_q == c_zero);
    assign bus.at_lim = (r_q == r_wl);

endmodule
`default_nettype wire

// File: doc/counter_universal_wrap.md
Name: counter_universal_wrap

Overview:
- Parametrised N-bit universal counter/shift register with a programmable wrap limit.
- Supports parallel load, increment, decrement, shift left/right with serial-in or rotate, and a one-cycle wrap pulse.
- Serves as the generic timing/sequencing counter for datapath and control blocks.
- Successor to the fixed 4-bit load/inc/dec/shift counter; adds width parametrisation, a stored limit register, clock enable, rotate mode, status flags and a shifted-out bit.

Parameters:
- WIDTH, 8, counter/shift register width in bits (>= 2).
- LIM_RST, all ones ({WIDTH{1'b1}}), reset value of the internal limit register WL.

Ports:
- C  input  1  clock; all state changes on posedge C.
- R  input  1  reset; synchronous, active-high.
- EN  input  1  operation enable; gates L/INC/DEC/SHL/SHR.
- D  input  WIDTH  parallel load data for Q and for WL.
- L  input  1  load Q from D.
- LW  input  1  load limit register WL from D.
- INC  input  1  increment with wrap at WL.
- DEC  input  1  decrement with wrap to WL.
- SHL  input  1  shift left.
- SHR  input  1  shift right.
- ROT  input  1  1 = shifts rotate; 0 = shifts take SIN.
- SIN  input  1  serial input bit for shifts.
- Q  output  WIDTH  counter value (registered).
- WL_Q  output  WIDTH  current limit register value (registered).
- WRAP  output  1  registered one-cycle pulse on a wrap event.
- SOUT  output  1  registered bit shifted out by the last shift.
- ZERO  output  1  combinational, Q == 0.
- AT_LIM  output  1  combinational, Q == WL.

Behaviour:
- Interface: single clock C; R is synchronous and active-high, sampled only on posedge C.
- Reset (R=1 at posedge C): Q=0, WL=LIM_RST, WRAP=0, SOUT=0. R overrides every other input, including LW.
- WL update: when LW=1 and R=0, WL<=D.
  - Independent of EN and of the Q operation; L and LW in the same cycle both load from D.
  - Q-path comparisons in that cycle use the old WL. The new WL is effective from the next cycle.
- Q operation priority when R=0 and EN=1: L > INC > DEC > SHL > SHR. Exactly one operation executes per cycle.
- EN=0: Q, SOUT hold; WRAP<=0; LW still acts.
- L: Q<=D.
- INC:
  - If Q >= WL: Q<=0, WRAP<=1.
  - Else: Q<=Q+1.
  - Q > WL (e.g. after lowering WL) therefore wraps to 0 on the next INC.
- DEC:
  - If Q == 0: Q<=WL, WRAP<=1.
  - Else: Q<=Q-1.
  - No clamping when Q > WL; Q counts down normally.
- SHL: Q<={Q[WIDTH-2:0], ROT ? Q[WIDTH-1] : SIN}; SOUT<=Q[WIDTH-1].
- SHR: Q<={ROT ? Q[0] : SIN, Q[WIDTH-1:1]}; SOUT<=Q[0].
- WRAP is 1 only in the cycle after a wrap event; otherwise 0. No back-to-back merging: each wrap produces its own pulse.
- SOUT updates only on an executed shift; otherwise it holds.
- No operation selected with EN=1: Q holds, WRAP<=0.
- All arithmetic is modulo 2^WIDTH; no carry output beyond WRAP.
- WL=0 is legal:
  - INC from 0 wraps every cycle (WRAP stays high continuously).
  - DEC from 0 loads 0 and pulses WRAP.

Test Plan (WIDTH=8):
- Reset, then INC held with WL=5 (loaded via LW=1, D=5) -> Q sequence 0,1,2,3,4,5,0,1. WRAP=1 only in the cycle Q returns to 0. AT_LIM=1 when Q=5.
- Q=0, WL=9, DEC for 3 cycles -> Q=9,8,7. WRAP pulses once with Q=9. ZERO=1 only before the first DEC.
- L=1 with D=0xA5, then SHL ROT=0 SIN=1 -> Q=0x4B, SOUT=1. Then SHR ROT=1 -> Q=0xA5, SOUT=1.
- L=1 and INC=1 simultaneously with D=0x20 -> Q=0x20 (load wins), WRAP=0. INC+DEC+SHL together with Q=3, WL=0xFF -> Q=4.
- Q=0x30, WL=0xFF, then LW=1 with D=0x10 alongside INC -> that cycle Q=0x31 (old WL). Next INC -> Q=0, WRAP=1.
- Mid-count at Q=0x07 with EN=1, INC=1, LW=1, D=0x44, R=1 -> next cycle Q=0, WL_Q=0xFF, WRAP=0, SOUT=0. EN=0 with INC=1 for 4 cycles -> Q holds.
